score_max_tracker: RTL

Streaming online-softmax running-maximum stage that sits directly upstream of the exp-multiply stage. For each query row it accepts one signed score per key, tracks the row's running maximum, and emits the score together with the previous and updated running maximum. The exp-multiply stage consumes these to form exp(score − m_new) and the rescale factor exp(m_prev − m_new). A key counter frames rows so the running maximum resets automatically at each row boundary.

---
 rtl/score_max_tracker.sv | 83 ++++++++
 1 files changed

// File: rtl/score_max_tracker.sv
// Online-softmax running-maximum stage: frames scores into rows of KEYS_PER_ROW
// and emits each score with the row maximum before and after it, one register stage.
module score_max_tracker #(
    parameter int INT_W        = 8,
    parameter int KEYS_PER_ROW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    output logic             rdy_out,
    input  logic [INT_W-1:0] s_in,
    output logic             vld_out,
    input  logic             rdy_in,
    output logic [INT_W-1:0] s_out,
    output logic [INT_W-1:0] m_new_out,
    output logic [INT_W-1:0] m_prev_out,
    output logic             first_out,
    output logic             last_out
);

    localparam int               K_W     = (KEYS_PER_ROW > 1) ? $clog2(KEYS_PER_ROW) : 1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(KEYS_PER_ROW - 1);
    localparam logic [INT_W-1:0] MIN_VAL = {1'b1, {(INT_W-1){1'b0}}};

    logic             valid_reg;
    logic [K_W-1:0]   k_reg;
    logic [INT_W-1:0] m_reg;
    logic [INT_W-1:0] s_reg;
    logic [INT_W-1:0] m_new_reg;
    logic [INT_W-1:0] m_prev_reg;
    logic             first_reg;
    logic             last_reg;

    logic             accept;
    logic             row_start;
    logic             row_end;
    logic [INT_W-1:0] m_prev_next;
    logic [INT_W-1:0] m_new_next;
    logic [K_W-1:0]   k_next;

    assign rdy_out = rdy_in || !valid_reg;
    assign accept  = vld_in && rdy_out;

    assign row_start = (k_reg == '0);
    assign row_end   = (k_reg == K_LAST);

    // m_reg is left stale across a row boundary; key 0 ignores it via MIN_VAL.
    assign m_prev_next = row_start ? MIN_VAL : m_reg;
    assign m_new_next  = ($signed(s_in) > $signed(m_prev_next)) ? s_in : m_prev_next;
    assign k_next      = row_end ? '0 : k_reg + K_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            k_reg      <= '0;
            m_reg      <= MIN_VAL;
            s_reg      <= '0;
            m_new_reg  <= '0;
            m_prev_reg <= '0;
            first_reg  <= 1'b0;
            last_reg   <= 1'b0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            k_reg      <= k_next;
            m_reg      <= m_new_next;
            s_reg      <= s_in;
            m_new_reg  <= m_new_next;
            m_prev_reg <= m_prev_next;
            first_reg  <= row_start;
            last_reg   <= row_end;
        end else if (rdy_in) begin
            valid_reg <= 1'b0;
        end
    end

    assign vld_out    = valid_reg;
    assign s_out      = s_reg;
    assign m_new_out  = m_new_reg;
    assign m_prev_out = m_prev_reg;
    assign first_out  = first_reg;
    assign last_out   = last_reg;

endmodule
